packet_segmenter_axis: RTL
==========================

// Module: packet_segmenter_axis
// PURPOSE
//  Width-converting segmenter between the DMA read path and the RDMA packet
//  builder, driven by a per-message end marker. Accepts IN_W-bit beats with
//  valid/ready/last and emits OUT_W-bit beats with valid/ready/last/keep.
//  Supports any IN_W:OUT_W ratio. Zero-pads and byte-masks the final partial
//  beat of a message. Asserts oLAST at packet boundaries of MAX_PKT_BEATS
//  beats and at end of message.
// PARAMETERS
//  IN_W           128  input beat width in bits; multiple of 8
//  OUT_W          64   output beat width in bits; multiple of 8
//  MAX_PKT_BEATS  4    output beats per packet (MTU / OUT_W bytes); >= 1
//  Derived: LCM = lcm(IN_W,OUT_W); CAP = 2*LCM buffer bits; KEEP_W = OUT_W/8
// PORTS
//  iClk          in   1        clock; all logic on posedge
//  iRst          in   1        synchronous reset, active-high
//  iDMA_DATA     in   IN_W     input beat
//  iVALID        in   1        input beat valid
//  iLAST         in   1        input beat is the last of its message
//  oREADY        out  1        block can accept an input beat this cycle
//  oDATA_PACKET  out  OUT_W    output beat; bits [7:0] = first byte
//  oKEEP         out  KEEP_W   byte enables; contiguous from bit 0
//  oLAST         out  1        last beat of a packet or of a message
//  oVALID        out  1        output beat valid
//  iREADY        in   1        downstream accepts the output beat
// BEHAVIOUR
//  - Reset: oVALID=0, oLAST=0, oKEEP=0, oDATA_PACKET=0, oREADY=0 during reset.
//    Reset clears pointers, count, eom_pending and beat_cnt.
//    Reset mid-message discards all buffered data, with no partial emission.
//  - Input handshake: a beat is accepted on a posedge with iVALID && oREADY.
//    - oREADY = !eom_pending && (count + IN_W <= CAP).
//    - oREADY depends on registers only, never on iVALID.
//  - Buffer: ring of CAP bits with wr_ptr/rd_ptr in bits, modulo CAP.
//    - A write stores at [wr_ptr +: IN_W]; a read takes [rd_ptr +: OUT_W].
//    - CAP is a multiple of both widths, so no access straddles the wrap.
//    - count is clog2(CAP)+1 bits.
//    - Simultaneous write and read in one cycle: count += IN_W - OUT_W.
//  - End of message:
//    - Accepting a beat with iLAST sets eom_pending and drops oREADY.
//    - Only one message is in flight at a time.
//    - While eom_pending and 0 < count < OUT_W, the next output beat is partial:
//      data bits >= count are zeroed; oKEEP = (1<<(count/8))-1; oLAST=1.
//    - On that final beat's load: wr_ptr=rd_ptr=count=0, eom_pending=0,
//      beat_cnt=0. oREADY may rise the following cycle.
//    - A final full beat that leaves count==0 gets the same treatment.
//    - A beat is full when count >= OUT_W. A full beat gets oKEEP all-ones.
//  - Output stage:
//    - One holding register, loaded when (!oVALID || iREADY) && beat available.
//    - While oVALID && !iREADY, all outputs stay bit-stable.
//    - oVALID deasserts after a transfer if no beat is available.
//    - Sustains one beat per cycle.
//  - Packetisation:
//    - beat_cnt counts loaded beats 0..MAX_PKT_BEATS-1.
//    - oLAST=1 when beat_cnt==MAX_PKT_BEATS-1 or on the message's final beat.
//    - beat_cnt wraps to 0 after any oLAST beat.
//  - Latency:
//    - Input accepted at edge k; if count >= OUT_W afterwards, oVALID is high
//      after edge k+1.
//    - The same applies when IN_W == OUT_W. There is no bypass path.
//  - Data arriving with iVALID && !oREADY is not accepted and must be held by
//    the source.
// STRUCTURE
//  - Package rdma_seg_pkg holds:
//    - gcd()/lcm() functions;
//    - keep_from_bits(nbits, KEEP_W);
//    - typedef seg_beat_t {data, keep, last}.
//  - Sub-module seg_output_stage (parameter OUT_W) contains:
//    - the holding register for seg_beat_t;
//    - load/hold logic driven by valid_in/ready.
//  - The top contains the ring buffer, pointers, count, eom_pending and
//    beat_cnt.
// TESTING
//  - IN_W=128, OUT_W=64, MAX=4. Send one beat 0x0F..00 (bytes 0..15) with
//    iLAST, iREADY=1.
//    -> 2 beats: 0x07..00 with oLAST=0, then 0x0F..08 with oLAST=1;
//       oKEEP=0xFF on both.
//  - IN_W=32, OUT_W=64. Send 3 beats 0x03020100, 0x07060504, 0x0B0A0908,
//    with iLAST on the 3rd.
//    -> beat 1: 0x0706050403020100 with oKEEP=0xFF, oLAST=0;
//    -> beat 2: 0x000000000B0A0908 with oKEEP=0x0F, oLAST=1.
//  - IN_W=128, OUT_W=64, MAX=2. Send a 3-beat message.
//    -> 6 output beats, with oLAST on beats 2, 4 and 6.
//  - Hold iREADY=0 for 20 cycles while streaming.
//    -> oDATA/oKEEP/oLAST stay stable, no beat is lost or duplicated.
//    -> oREADY falls when count+IN_W > CAP; data is in order after release.
//  - IN_W=96, OUT_W=64 (CAP=384), streaming 8 beats with wrap-around.
//    -> 12 beats, byte order preserved across the ring wrap.
//  - Assert iRst for 1 cycle mid-message with 2 beats buffered.
//    -> next cycle oVALID=0; after reset a new message emits only new data.

Source files
------------

// File: rtl/rdma_seg_pkg.sv
// Shared types and helpers for the packet segmenter.
// Holds the gcd/lcm helpers used to size the ring buffer, the byte-enable
// generator for partial beats, and the beat record passed from the ring
// buffer to the output holding register. The beat record is sized for the
// widest supported output beat (OUT_W below SEG_DATA_MAX); narrower
// configurations only use the low bits.
package rdma_seg_pkg;

    localparam int SEG_DATA_MAX = 1024;
    localparam int SEG_KEEP_MAX = SEG_DATA_MAX / 8;

    typedef struct packed {
        logic [SEG_DATA_MAX-1:0] data;
        logic [SEG_KEEP_MAX-1:0] keep;
        logic                    last;
    } seg_beat_t;

    // Euclid's algorithm; only ever evaluated at elaboration time.
    function automatic int gcd(input int a, input int b);
        int x;
        int y;
        int t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int lcm(input int a, input int b);
        return (a / gcd(a, b)) * b;
    endfunction

    // Contiguous byte enables from bit 0 covering nbits of payload,
    // limited to keepW lanes.
    function automatic logic [SEG_KEEP_MAX-1:0] keep_from_bits(input int nbits, input int keepW);
        logic [SEG_KEEP_MAX-1:0] k;
        k = '0;
        for (int i = 0; i < SEG_KEEP_MAX; i++) begin
            if ((i < keepW) && (i < nbits / 8)) begin
                k[i] = 1'b1;
            end
        end
        return k;
    endfunction

endpackage

// File: rtl/seg_output_stage.sv
// Output holding register for the packet segmenter.
// Ports:
//   clk_i, rst_i  clock and synchronous active-high reset
//   valid_i       a beat is available upstream this cycle
//   beat_i        the beat that would be loaded
//   ready_i       downstream accepts the currently held beat
//   accept_o      the register can take a new beat this cycle
//   valid_o       held beat is valid
//   data_o/keep_o/last_o  held beat fields, OUT_W wide
module seg_output_stage
    import rdma_seg_pkg::*;
#(
    parameter int OUT_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    input  seg_beat_t        beat_i,
    input  logic             ready_i,
    output logic             accept_o,
    output logic             valid_o,
    output logic [OUT_W-1:0] data_o,
    output logic [OUT_W/8-1:0] keep_o,
    output logic             last_o
);

    localparam int KEEP_W = OUT_W / 8;

    seg_beat_t beat_q;
    logic      valid_q;
    logic      unusedBits;

    // The register may take a new beat when it is empty or its current beat
    // is leaving this cycle, which keeps one beat per cycle under full flow.
    assign accept_o = !valid_q || ready_i;

    // Load a new beat when possible; otherwise drop valid once the held beat
    // has been taken. While stalled nothing changes, so outputs stay stable.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            beat_q  <= '0;
            valid_q <= 1'b0;
        end else if (valid_i && accept_o) begin
            beat_q  <= beat_i;
            valid_q <= 1'b1;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // The beat record is sized for the widest configuration; the upper bits
    // are always zero here and are folded away.
    assign unusedBits = ^{beat_q.data[SEG_DATA_MAX-1:OUT_W], beat_q.keep[SEG_KEEP_MAX-1:KEEP_W]};

    assign valid_o = valid_q;
    assign data_o  = beat_q.data[OUT_W-1:0];
    assign keep_o  = beat_q.keep[KEEP_W-1:0];
    assign last_o  = beat_q.last;

endmodule

// File: rtl/packet_segmenter_axis.sv
// Width-converting packet segmenter between the DMA read path and the RDMA
// packet builder. IN_W-bit input beats are written into a ring buffer and
// read back as OUT_W-bit beats, with the final partial beat of a message
// zero-padded and byte-masked, and oLAST marking packet ends
// (every MAX_PKT_BEATS beats) and message ends.
// Ports:
//   iClk, iRst           clock and synchronous active-high reset
//   iDMA_DATA/iVALID/iLAST/oREADY      input beat handshake
//   oDATA_PACKET/oKEEP/oLAST/oVALID/iREADY  output beat handshake
module packet_segmenter_axis
    import rdma_seg_pkg::*;
#(
    parameter int IN_W          = 128,
    parameter int OUT_W         = 64,
    parameter int MAX_PKT_BEATS = 4
) (
    input  logic               iClk,
    input  logic               iRst,
    input  logic [IN_W-1:0]    iDMA_DATA,
    input  logic               iVALID,
    input  logic               iLAST,
    output logic               oREADY,
    output logic [OUT_W-1:0]   oDATA_PACKET,
    output logic [OUT_W/8-1:0] oKEEP,
    output logic               oLAST,
    output logic               oVALID,
    input  logic               iREADY
);

    localparam int LCM    = lcm(IN_W, OUT_W);
    localparam int CAP    = 2 * LCM;
    localparam int KEEP_W = OUT_W / 8;
    localparam int PTR_W  = $clog2(CAP);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BC_W   = (MAX_PKT_BEATS > 1) ? $clog2(MAX_PKT_BEATS) : 1;

    localparam logic [CNT_W-1:0] CAP_C   = CNT_W'(CAP);
    localparam logic [CNT_W-1:0] IN_C    = CNT_W'(IN_W);
    localparam logic [CNT_W-1:0] OUT_C   = CNT_W'(OUT_W);
    localparam logic [BC_W-1:0]  BC_LAST = BC_W'(MAX_PKT_BEATS - 1);

    logic [CAP-1:0]   ring_q;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             eomPending_q, eomPending_d;
    logic [BC_W-1:0]  beatCnt_q, beatCnt_d;

    logic             wrEn;
    logic             beatAvail;
    logic             finalBeat;
    logic             stageAccept;
    logic             loadEn;
    logic [OUT_W-1:0] rdData;
    logic [OUT_W-1:0] maskedData;
    seg_beat_t        beat_d;

    // Pointers are bit offsets into the ring; CAP is a multiple of both beat
    // widths, so advancing by one beat wraps exactly onto zero.
    function automatic logic [PTR_W-1:0] ptrAdvance(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] step);
        logic [CNT_W-1:0] s;
        s = {1'b0, p} + step;
        if (s >= CAP_C) begin
            s = s - CAP_C;
        end
        return PTR_W'(s);
    endfunction

    // Input side: accept only when a whole input beat fits and no finished
    // message is still draining, so one message is in flight at a time.
    assign oREADY = !iRst && !eomPending_q && ((count_q + IN_C) <= CAP_C);
    assign wrEn   = iVALID && oREADY;

    // A full beat is available whenever OUT_W bits are buffered; once the
    // message has ended, any remaining bits form the final (maybe partial) beat.
    assign beatAvail = (count_q >= OUT_C) || (eomPending_q && (count_q != '0));
    assign finalBeat = eomPending_q && (count_q != '0) && (count_q <= OUT_C);
    assign loadEn    = beatAvail && stageAccept;

    assign rdData = ring_q[rdPtr_q +: OUT_W];

    // Build the candidate output beat: bits beyond the buffered count are
    // zeroed so stale ring contents never leak into a partial beat.
    always_comb begin
        maskedData = '0;
        for (int i = 0; i < OUT_W; i++) begin
            maskedData[i] = rdData[i] & (CNT_W'(i) < count_q);
        end
        beat_d = '0;
        beat_d.data[OUT_W-1:0] = maskedData;
        beat_d.keep = keep_from_bits((count_q >= OUT_C) ? OUT_W : int'(count_q), KEEP_W);
        beat_d.last = finalBeat || (beatCnt_q == BC_LAST);
    end

    // Next-state for pointers, fill count, end-of-message flag and packet
    // beat counter. Loading the final beat of a message rewinds everything
    // to zero; a write can never coincide with it because the input is
    // closed while the end of message is pending.
    always_comb begin
        wrPtr_d      = wrPtr_q;
        rdPtr_d      = rdPtr_q;
        count_d      = count_q;
        eomPending_d = eomPending_q;
        beatCnt_d    = beatCnt_q;
        if (loadEn && finalBeat) begin
            wrPtr_d      = '0;
            rdPtr_d      = '0;
            count_d      = '0;
            eomPending_d = 1'b0;
            beatCnt_d    = '0;
        end else begin
            if (wrEn) begin
                wrPtr_d = ptrAdvance(wrPtr_q, IN_C);
                if (iLAST) begin
                    eomPending_d = 1'b1;
                end
            end
            if (loadEn) begin
                rdPtr_d   = ptrAdvance(rdPtr_q, OUT_C);
                beatCnt_d = beat_d.last ? '0 : beatCnt_q + BC_W'(1);
            end
            count_d = count_q + (wrEn ? IN_C : '0) - (loadEn ? OUT_C : '0);
        end
    end

    // Control state registers; reset discards everything buffered.
    always_ff @(posedge iClk) begin
        if (iRst) begin
            wrPtr_q      <= '0;
            rdPtr_q      <= '0;
            count_q      <= '0;
            eomPending_q <= 1'b0;
            beatCnt_q    <= '0;
        end else begin
            wrPtr_q      <= wrPtr_d;
            rdPtr_q      <= rdPtr_d;
            count_q      <= count_d;
            eomPending_q <= eomPending_d;
            beatCnt_q    <= beatCnt_d;
        end
    end

    // Ring storage needs no reset: the count alone decides what is valid.
    always_ff @(posedge iClk) begin
        if (wrEn) begin
            ring_q[wrPtr_q +: IN_W] <= iDMA_DATA;
        end
    end

    seg_output_stage #(
        .OUT_W(OUT_W)
    ) uOutStage (
        .clk_i   (iClk),
        .rst_i   (iRst),
        .valid_i (beatAvail),
        .beat_i  (beat_d),
        .ready_i (iREADY),
        .accept_o(stageAccept),
        .valid_o (oVALID),
        .data_o  (oDATA_PACKET),
        .keep_o  (oKEEP),
        .last_o  (oLAST)
    );

endmodule
